ss_write_trace: RTL
===================

# ss_write_trace

Captures the 6502 address/data pair of each write cycle executed while single-cycle stepping, so the front panel can show what the last step(s) wrote. Sits directly downstream of the single-step core and is clocked by its write-cycle clock (`wc_clk`, rising at PHI2 fall of a write cycle). It is cleared by that core's button-down preset (`wc_preset`), so each step starts with an empty trace. Stored entries are read back combinationally by a panel-side select.

## Interface
Parameters:
- DEPTH, 4, trace entries; legal values 2 or 4.
- AW, 16, address width.
- DW, 8, data width.

Ports:
- wc_clk  in  1  capture clock; write-cycle clock from the single-step core.
- wc_preset  in  1  reset; asynchronous, active-high.
- rd  in  1  6502 R/W (1 = read), sampled at wc_clk rise.
- si_n  in  1  single-instruction button, active low, sampled at wc_clk rise.
- addr  in  AW  6502 address bus.
- data  in  DW  6502 data bus.
- sel  in  log2(DEPTH)  read select; 0 = most recent write, 1 = previous, etc.
- q_addr  out  AW  address of selected entry.
- q_data  out  DW  data of selected entry.
- q_valid  out  1  selected entry holds a capture from the current step.
- wcount  out  3  writes captured since reset, saturating at 7.
- overflow  out  1  sticky: at least one entry has been overwritten.

## Operation
- Capture qualifier: on a rising wc_clk, capture only if rd == 0 and si_n == 1. Any other edge changes no state.
- Storage: ring of DEPTH entries {addr, data, valid}, write pointer wp (log2(DEPTH) bits).
- On capture:
  - entry[wp] <= {addr, data, 1}.
  - wp <= wp + 1, modulo DEPTH; wraps silently.
  - wcount <= min(wcount + 1, 7).
- Overflow: on a capture while entry[wp].valid == 1 (ring full), the oldest entry is overwritten and overflow <= 1. overflow stays set until reset.
- Readout: entry index = (wp − 1 − sel) mod DEPTH. q_addr/q_data/q_valid come from that entry, purely combinational.
- Unused sel: if DEPTH = 2, sel is 1 bit wide.
- Reset (wc_preset high): wp = 0, all valid = 0, all stored addr/data = 0, wcount = 0, overflow = 0. Outputs therefore reset to q_addr = 0, q_data = 0, q_valid = 0, wcount = 0, overflow = 0.
- Reset dominates: wc_clk edges while wc_preset is high are ignored. Deassertion mid-step leaves an empty trace and the next qualified edge captures into entry 0.

## Timing
- Capture latency: stored state and wcount/overflow update on the qualified wc_clk rising edge and are valid before the next PHI2 rise.
- Read latency: zero clocks; q_* follow sel combinationally.
- addr/data/rd/si_n must be stable around the wc_clk rise. The 6502 write hold after PHI2 fall provides this; no internal resynchronisation.
- No handshake. Every qualified edge is an unconditional capture, and back-to-back write cycles (e.g. RMW, BRK stack pushes) each capture.
- Simultaneous wc_preset rise and wc_clk rise: reset wins, nothing captured.

## Configuration
- WT_ADDR_CAPTURE_EN defined: address storage is built. q_addr is as above.
- WT_ADDR_CAPTURE_EN undefined: no address registers are built and q_addr is tied to 0. Data, valid, wcount, overflow and pointer behaviour are unchanged. This saves AW×DEPTH macrocells on the XC9500.

## Test plan
- Reset: wc_preset pulse, sel = 0..DEPTH−1 -> q_valid = 0, q_addr = 0x0000, q_data = 0x00, wcount = 0, overflow = 0.
- Single write: rd = 0, si_n = 1, addr = 0x01FF, data = 0xA5, one wc_clk rise -> sel 0 gives 0x01FF/0xA5/valid = 1; sel 1 gives valid = 0; wcount = 1.
- Qualifier: wc_clk rises with rd = 1, then with si_n = 0 -> no state change, wcount stays 0.
- Wrap/overflow (DEPTH = 4): 5 writes to 0x0200..0x0204 with data 0x10..0x14 -> sel 0..3 give 0x0204..0x0201, overflow = 1, wcount = 5. Continue to 9 writes -> wcount = 7.
- Reset mid-operation: after 3 writes, assert wc_preset while wc_clk toggles, then deassert and do 1 write of 0x0300/0x77 -> sel 0 valid with 0x0300/0x77, sel 1 invalid, wcount = 1, overflow = 0.
- Config: build without WT_ADDR_CAPTURE_EN and repeat the single-write case -> q_addr = 0x0000, q_data = 0xA5, valid = 1.

Source files
------------

// File: rtl/ss_write_trace.sv
// Write-cycle trace for single-step mode: keeps the last DEPTH 6502 writes of the current step.
// Optional macro WT_ADDR_CAPTURE_EN builds the address store; without it q_addr reads as zero.
`timescale 1ns/1ps
module ss_write_trace #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 8,
  localparam int SW   = $clog2(DEPTH)
) (
  input  logic          wc_clk,
  input  logic          wc_preset,
  input  logic          rd,
  input  logic          si_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic [SW-1:0] sel,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_data,
  output logic          q_valid,
  output logic [2:0]    wcount,
  output logic          overflow
);

  // No handshake: every rising wc_clk with rd low and si_n high is an
  // unconditional capture; all other edges leave state untouched.
  logic             capture;
  logic [SW-1:0]    wp;
  logic [SW-1:0]    rd_idx;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  assign capture = !rd && si_n;

  always_ff @(posedge wc_clk or posedge wc_preset) begin
    if (wc_preset) begin
      wp       <= '0;
      valid_q  <= '0;
      wcount   <= 3'd0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (capture) begin
      data_q[wp]  <= data;
      valid_q[wp] <= 1'b1;
      wp          <= wp + SW'(1);
      if (wcount != 3'd7) begin
        wcount <= wcount + 3'd1;
      end
      // A still-valid slot under the write pointer means the ring is full.
      if (valid_q[wp]) begin
        overflow <= 1'b1;
      end
    end
  end

  // DEPTH is a power of two, so the SW-bit subtraction wraps modulo DEPTH.
  assign rd_idx  = wp - SW'(1) - sel;
  assign q_data  = data_q[rd_idx];
  assign q_valid = valid_q[rd_idx];

`ifdef WT_ADDR_CAPTURE_EN
  logic [AW-1:0] addr_q [DEPTH];

  always_ff @(posedge wc_clk or posedge wc_preset) begin
    if (wc_preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else if (capture) begin
      addr_q[wp] <= addr;
    end
  end

  assign q_addr = addr_q[rd_idx];
`else
  logic addr_unused;

  assign addr_unused = ^addr;
  assign q_addr      = '0;
`endif

endmodule
